// File: rtl/matrix_pkg.sv
// Shared constants, FSM state encoding and dimension check for the matrix print controller.
package matrix_pkg;

  localparam int MAX_DIM_DEFAULT = 5;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    CONV,
    EMIT_DIG,
    EMIT_SEP,
    EMIT_NL,
    DONE
  } state_t;

  // A dimension is usable when it is non-zero and fits the stored matrix.
  function automatic logic dim_ok(input logic [2:0] dim, input int max_dim);
    return (dim != 3'd0) && (int'(dim) <= max_dim);
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Combinational binary-to-BCD (shift-and-add-3) with a count of significant digits.
module bin2bcd #(
  parameter int ELEM_W = 8
) (
  input  logic [ELEM_W-1:0] bin,
  output logic [3:0]        hundreds,
  output logic [3:0]        tens,
  output logic [3:0]        ones,
  output logic [1:0]        ndig
);

  logic [ELEM_W+11:0] sh;

  // Values above 999 do not fit three digits; ELEM_W is expected to stay at 8 or 9.
  always_comb begin
    sh = {12'd0, bin};
    for (int i = 0; i < ELEM_W; i++) begin
      for (int d = 0; d < 3; d++) begin
        if (sh[ELEM_W+4*d +: 4] >= 4'd5) begin
          sh[ELEM_W+4*d +: 4] = sh[ELEM_W+4*d +: 4] + 4'd3;
        end
      end
      sh = sh << 1;
    end
    ones     = sh[ELEM_W   +: 4];
    tens     = sh[ELEM_W+4 +: 4];
    hundreds = sh[ELEM_W+8 +: 4];
    if (hundreds != 4'd0) begin
      ndig = 2'd3;
    end else if (tens != 4'd0) begin
      ndig = 2'd2;
    end else begin
      ndig = 2'd1;
    end
  end

endmodule

// File: rtl/matrix_print_ctrl.sv
// Reads a stored matrix element by element and streams it as decimal ASCII text,
// space-separated within a row and newline-terminated per row, over a valid/ready byte port.
module matrix_print_ctrl
  import matrix_pkg::*;
#(
  parameter int MAX_DIM = MAX_DIM_DEFAULT,
  parameter int ELEM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        rows,
  input  logic [2:0]        cols,
  output logic              rd_en,
  output logic [2:0]        rd_row,
  output logic [2:0]        rd_col,
  input  logic [ELEM_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state_reg, state_next;
  logic [2:0]        rows_reg, cols_reg;
  logic [2:0]        row_reg, col_reg;
  logic [ELEM_W-1:0] elem_reg;
  logic [3:0]        digit_reg [0:2];
  logic [1:0]        dig_idx_reg;
  logic              err_reg;

  logic [3:0]        bcd_h, bcd_t, bcd_o;
  logic [1:0]        bcd_n;
  logic [7:0]        dig_ascii [0:2];
  logic              start_ok, start_bad;
  logic              last_col, last_row, last_digit;

  assign start_ok   = start && dim_ok(rows, MAX_DIM) && dim_ok(cols, MAX_DIM);
  assign start_bad  = start && !start_ok;
  assign last_col   = (col_reg == cols_reg - 3'd1);
  assign last_row   = (row_reg == rows_reg - 3'd1);
  assign last_digit = (dig_idx_reg == 2'd0);

  bin2bcd #(.ELEM_W(ELEM_W)) u_bin2bcd (
    .bin      (elem_reg),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .ones     (bcd_o),
    .ndig     (bcd_n)
  );

  // digit_reg[0] is the ones digit; dig_idx_reg counts down to emit MSB first.
  for (genvar gi = 0; gi < 3; gi++) begin : g_ascii
    assign dig_ascii[gi] = ASCII_ZERO | {4'b0000, digit_reg[gi]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start_ok) state_next = FETCH;
      FETCH:    state_next = WAIT;
      WAIT:     state_next = CONV;
      CONV:     state_next = EMIT_DIG;
      EMIT_DIG: if (tx_ready && last_digit) state_next = last_col ? EMIT_NL : EMIT_SEP;
      EMIT_SEP: if (tx_ready) state_next = FETCH;
      EMIT_NL:  if (tx_ready) state_next = last_row ? DONE : FETCH;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_reg    <= 3'd0;
      cols_reg    <= 3'd0;
      row_reg     <= 3'd0;
      col_reg     <= 3'd0;
      elem_reg    <= '0;
      dig_idx_reg <= 2'd0;
      err_reg     <= 1'b0;
      for (int i = 0; i < 3; i++) digit_reg[i] <= 4'd0;
    end else begin
      err_reg <= (state_reg == IDLE) && start_bad;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            rows_reg <= rows;
            cols_reg <= cols;
            row_reg  <= 3'd0;
            col_reg  <= 3'd0;
          end
        end
        // rd_data is only valid during WAIT, so it is captured on the edge into CONV.
        WAIT: elem_reg <= rd_data;
        CONV: begin
          digit_reg[2] <= bcd_h;
          digit_reg[1] <= bcd_t;
          digit_reg[0] <= bcd_o;
          dig_idx_reg  <= bcd_n - 2'd1;
        end
        EMIT_DIG: if (tx_ready && !last_digit) dig_idx_reg <= dig_idx_reg - 2'd1;
        EMIT_SEP: if (tx_ready) col_reg <= col_reg + 3'd1;
        EMIT_NL: begin
          if (tx_ready) begin
            col_reg <= 3'd0;
            row_reg <= row_reg + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_row = row_reg;
  assign rd_col = col_reg;
  assign err    = err_reg;

  always_comb begin
    rd_en    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_reg)
      FETCH: begin
        rd_en = 1'b1;
        busy  = 1'b1;
      end
      WAIT, CONV: busy = 1'b1;
      EMIT_DIG: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        case (dig_idx_reg)
          2'd2:    tx_data = dig_ascii[2];
          2'd1:    tx_data = dig_ascii[1];
          default: tx_data = dig_ascii[0];
        endcase
      end
      EMIT_SEP: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = ASCII_SPACE;
      end
      EMIT_NL: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = ASCII_LF;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matrix_print_ctrl.sv
// Directed table-driven bench for matrix_print_ctrl with a registered-read matrix memory model.
module tb_matrix_print_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [2:0] rows = 3'd0;
  logic [2:0] cols = 3'd0;
  logic       rd_en;
  logic [2:0] rd_row, rd_col;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy, done, err;

  matrix_print_ctrl #(.MAX_DIM(5), .ELEM_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rows     (rows),
    .cols     (cols),
    .rd_en    (rd_en),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Matrix memory: data valid only in the cycle right after rd_en, junk otherwise.
  logic [7:0] mem [0:7][0:7];
  always @(posedge clk) rd_data <= rd_en ? mem[rd_row][rd_col] : 8'hEE;

  int ready_mode = 0;
  always @(posedge clk) begin
    #2;
    tx_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: collects transferred bytes, counts pulses and stall-hold violations.
  logic [7:0] got_q [$];
  int n_done = 0, n_err = 0, n_busy = 0, n_stall_bad = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && !(tx_valid && tx_data == prev_data)) n_stall_bad++;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (done) n_done++;
      if (err) n_err++;
      if (busy) n_busy++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  int n_checks = 0, n_fail = 0;
  int base_q, base_done, base_err, base_busy, base_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]     rows;
    logic [2:0]     cols;
    logic           rnd;
    logic           err_exp;
    logic [71:0]    m;
    logic [319:0]   exp;
    logic [7:0]     exp_len;
  } vec_t;

  function automatic vec_t mk_vec(input logic [2:0] r, input logic [2:0] c, input logic rnd,
                                  input logic e, input logic [71:0] m, input string s);
    vec_t v;
    v.rows    = r;
    v.cols    = c;
    v.rnd     = rnd;
    v.err_exp = e;
    v.m       = m;
    v.exp     = '0;
    for (int i = 0; i < s.len(); i++) v.exp[8*i +: 8] = s[i];
    v.exp_len = 8'(s.len());
    return v;
  endfunction

  task automatic snap();
    base_q     = got_q.size();
    base_done  = n_done;
    base_err   = n_err;
    base_busy  = n_busy;
    base_stall = n_stall_bad;
  endtask

  task automatic load(input vec_t t);
    for (int r = 0; r < int'(t.rows); r++)
      for (int c = 0; c < int'(t.cols); c++)
        mem[r][c] = t.m[8*(r*int'(t.cols)+c) +: 8];
  endtask

  task automatic pulse_start(input logic [2:0] r, input logic [2:0] c);
    @(negedge clk);
    rows  = r;
    cols  = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i = 0;
    while (n_done == base_done && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_done_seen"}, 32'(n_done != base_done), 32'd1);
    repeat (3) @(negedge clk);
    check({tag, "_done_count"}, 32'(n_done - base_done), 32'd1);
  endtask

  task automatic compare_stream(input string tag, input logic [319:0] e, input int len);
    int n = got_q.size() - base_q;
    check({tag, "_len"}, 32'(n), 32'(len));
    for (int i = 0; i < len && i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[base_q+i]), 32'(e[8*i +: 8]));
    check({tag, "_stall_hold"}, 32'(n_stall_bad - base_stall), 32'd0);
    $display("%s: %0d bytes received", tag, n);
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    string tag = $sformatf("vec%0d", idx);
    if (!t.err_exp) load(t);
    ready_mode = int'(t.rnd);
    snap();
    pulse_start(t.rows, t.cols);
    if (t.err_exp) begin
      repeat (4) @(negedge clk);
      check({tag, "_err_count"}, 32'(n_err - base_err), 32'd1);
      check({tag, "_no_bytes"}, 32'(got_q.size() - base_q), 32'd0);
      check({tag, "_busy_cycles"}, 32'(n_busy - base_busy), 32'd0);
      $display("%s: rows=%0d cols=%0d rejected", tag, t.rows, t.cols);
    end else begin
      wait_done(tag);
      check({tag, "_no_err"}, 32'(n_err - base_err), 32'd0);
      compare_stream(tag, t.exp, int'(t.exp_len));
    end
    ready_mode = 0;
  endtask

  vec_t vecs [8];
  vec_t v22;

  initial begin
    vecs[0] = mk_vec(3'd2, 3'd2, 1'b0, 1'b0, 72'({8'd0, 8'd100, 8'd23, 8'd1}), "1 23\n100 0\n");
    vecs[1] = mk_vec(3'd1, 3'd1, 1'b0, 1'b0, 72'(8'd255), "255\n");
    vecs[2] = mk_vec(3'd3, 3'd3, 1'b1, 1'b0,
                     {8'd42, 8'd255, 8'd0, 8'd200, 8'd99, 8'd10, 8'd9, 8'd8, 8'd7},
                     "7 8 9\n10 99 200\n0 255 42\n");
    vecs[3] = mk_vec(3'd1, 3'd5, 1'b0, 1'b0, 72'({8'd249, 8'd150, 8'd50, 8'd5, 8'd0}),
                     "0 5 50 150 249\n");
    vecs[4] = mk_vec(3'd5, 3'd1, 1'b0, 1'b0, 72'({8'd101, 8'd100, 8'd99, 8'd10, 8'd9}),
                     "9\n10\n99\n100\n101\n");
    vecs[5] = mk_vec(3'd0, 3'd2, 1'b0, 1'b1, 72'd0, "");
    vecs[6] = mk_vec(3'd2, 3'd6, 1'b0, 1'b1, 72'd0, "");
    vecs[7] = mk_vec(3'd7, 3'd3, 1'b0, 1'b1, 72'd0, "");
    v22 = vecs[0];

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mem[r][c] = 8'h00;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_rd_addr", 32'({rd_row, rd_col}), 32'd0);
    rst_n = 1'b1;
    $display("reset: outputs checked");

    // Fixed latency: start in cycle 0, rd_en in cycle 1, first byte in cycle 4
    mem[0][0] = 8'd255;
    snap();
    pulse_start(3'd1, 3'd1);
    check("lat_c1_rd_en", 32'(rd_en), 32'd1);
    check("lat_c1_addr", 32'({rd_row, rd_col}), 32'd0);
    check("lat_c1_busy", 32'(busy), 32'd1);
    check("lat_c1_tx_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("lat_c2_rd_en", 32'(rd_en), 32'd0);
    check("lat_c2_tx_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("lat_c3_tx_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("lat_c4_tx_valid", 32'(tx_valid), 32'd1);
    check("lat_c4_tx_data", 32'(tx_data), 32'h32);
    wait_done("lat");
    compare_stream("lat", vecs[1].exp, int'(vecs[1].exp_len));

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Start pulses while busy are ignored, valid or not
    load(v22);
    snap();
    pulse_start(3'd2, 3'd2);
    repeat (5) @(negedge clk);
    pulse_start(3'd1, 3'd1);
    repeat (4) @(negedge clk);
    pulse_start(3'd0, 3'd0);
    wait_done("busy_start");
    check("busy_start_no_err", 32'(n_err - base_err), 32'd0);
    compare_stream("busy_start", v22.exp, int'(v22.exp_len));

    // Reset while printing row 1, then a fresh run from row 0
    load(v22);
    snap();
    pulse_start(3'd2, 3'd2);
    begin
      int i = 0;
      while (got_q.size() < base_q + 6 && i < 200) begin
        @(negedge clk);
        i++;
      end
      check("rstmid_reach_row1", 32'(got_q.size() >= base_q + 6), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("rstmid_tx_valid", 32'(tx_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_rd_en", 32'(rd_en), 32'd0);
    check("rstmid_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    snap();
    pulse_start(3'd2, 3'd2);
    wait_done("rstmid");
    compare_stream("rstmid", v22.exp, int'(v22.exp_len));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
